vending_machine: RTL and testbench
==================================

Name: vending_machine

Overview:
Single-clock ticket vending controller. It accepts one coin code per clock cycle and accumulates credit. When the credit reaches the ticket price, it issues a one-cycle ticket pulse and clears the credit. It sits between the coin-acceptor front end, which presents an already-debounced 2-bit coin code each cycle, and the ticket dispenser driver.

Parameters:
- PRICE, 15, ticket price in cents; legal range 11..31.
- CREDIT_W, 5, credit register width in bits; must hold PRICE-1+10.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- coin  input  2  coin code sampled every rising edge:
  - 00 = penny (1c)
  - 01 = nickel (5c)
  - 10 = dime (10c)
  - 11 = no coin (idle)
- ticket  output  1  registered; high for exactly one cycle per ticket issued.

Behaviour:
- Reset:
  - rst low immediately forces credit = 0 and ticket = 0, independent of clk.
  - While rst is low, coin is ignored.
  - The first coin is counted on the first rising edge after rst goes high.
- Coin sampling:
  - coin is sampled on every rising edge; each edge with a non-idle code adds exactly one coin's value.
  - A code held for N cycles counts N coins.
  - No edge detection is performed; the upstream block presents one cycle per coin.
- Credit arithmetic:
  - sum = credit + value(coin), computed at CREDIT_W bits with no overflow possible, since max sum = PRICE-1+10.
  - value(11) = 0.
- State update per rising edge:
  - If sum >= PRICE: credit <= 0 and ticket <= 1. Excess over PRICE is forfeited; no change is returned and nothing carries over.
  - Else: credit <= sum and ticket <= 0.
- Credit states:
  - The implementation is a credit state machine S0..S(PRICE-1), one state per cent of credit held. It may be coded as an explicit FSM or as a counter with a comparator; the externally visible behaviour is identical.
  - Credit is never >= PRICE after an edge.
- Ticket timing:
  - ticket rises on the same edge that sampled the completing coin, i.e. it is valid in the cycle following that coin's sample cycle.
  - It falls on the next edge unless that edge also completes a purchase.
  - Back-to-back purchases are possible only if a single coin completes the price from 0; with PRICE = 15 this cannot happen, so ticket pulses are separated by >= 1 low cycle.
- Coin in the cycle after purchase: it is added to credit 0 normally and is not lost.
- Idle code 11: credit holds its value and ticket deasserts.
- Reset mid-accumulation: partial credit is discarded and no ticket is issued.
- Reset while ticket = 1: ticket drops immediately (asynchronous).
- Outputs are driven only from flops; there is no combinational path from coin to ticket.

Test Plan:
- Release rst; coins over 4 edges: penny, nickel, penny, dime → credit 1, 6, 7, then sum 17 ≥ 15 → ticket = 1 for one cycle, credit = 0 (2c forfeited).
- Pulse rst low for 2 ns mid-cycle, then two dimes on consecutive edges → credit 10, then ticket = 1 and credit = 0; verify ticket/credit clear asynchronously during the reset pulse.
- Three nickels → ticket = 1 on the 3rd edge (exact price, no excess); a following penny gives credit = 1, ticket = 0.
- Fifteen consecutive pennies → ticket stays 0 for edges 1-14 and is 1 after edge 15; code 11 for 5 cycles in between (after 7 pennies) holds credit at 7.
- Accumulate 14c (dime + 4 pennies), then assert rst low → credit = 0; then a nickel after release gives credit = 5 and no ticket.
- Dime, nickel, dime, nickel with no gaps → ticket pulses after the 2nd and 4th coins, each one cycle wide, low in between.

Source files
------------

// File: rtl/vending_machine.sv
// Ticket vending controller: accumulates coin credit and pulses `ticket` for one
// cycle when the credit reaches PRICE, forfeiting any excess.
module vending_machine #(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned CREDIT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  output logic       ticket
);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                ticket_q, ticket_d;
  logic [CREDIT_W-1:0] sum_s;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   return CREDIT_W'(1);
      2'b01:   return CREDIT_W'(5);
      2'b10:   return CREDIT_W'(10);
      default: return {CREDIT_W{1'b0}};
    endcase
  endfunction

  assign sum_s = credit_q + coin_value(coin);

  // Purchase completes when the sum reaches the price; leftover credit is dropped.
  always_comb begin
    credit_d = credit_q;
    ticket_d = 1'b0;
    if (sum_s >= CREDIT_W'(PRICE)) begin
      credit_d = {CREDIT_W{1'b0}};
      ticket_d = 1'b1;
    end else begin
      credit_d = sum_s;
      ticket_d = 1'b0;
    end
  end

  // Credit and ticket registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= {CREDIT_W{1'b0}};
      ticket_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ticket_q <= ticket_d;
    end
  end

  assign ticket = ticket_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine; expected ticket values are queued as each
// coin is driven and checked one cycle later.
`timescale 1ns/1ps
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       ticket;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  localparam logic [1:0] PENNY  = 2'b00;
  localparam logic [1:0] NICKEL = 2'b01;
  localparam logic [1:0] DIME   = 2'b10;
  localparam logic [1:0] IDLE   = 2'b11;

  vending_machine #(.PRICE(15), .CREDIT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .coin   (coin),
    .ticket (ticket)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_direct(input string tag, input logic e);
    checks++;
    assert (ticket === e) else begin
      errors++;
      $error("FAIL %s ticket=%0b expected=%0b", tag, ticket, e);
    end
  endtask

  task automatic pop_check(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty ticket=%0b expected=queued", tag, ticket);
    end else begin
      e = exp_q.pop_front();
      check_direct(tag, e);
    end
  endtask

  // One coin per cycle: drive at negedge, expect result after the next rising edge.
  task automatic step(input string tag, input logic [1:0] c, input logic e);
    @(negedge clk);
    coin = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Short asynchronous reset pulse in the middle of a cycle.
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1;
    check_direct(tag, 1'b0);
    #1;
    rst = 1'b1;
  endtask

  // Hold reset across a rising edge with a coin that must be ignored.
  task automatic reset_over_edge(input string tag, input logic [1:0] c);
    @(negedge clk);
    rst  = 1'b0;
    coin = c;
    @(posedge clk);
    #1;
    check_direct(tag, 1'b0);
    @(negedge clk);
    coin = IDLE;
    rst  = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    coin = IDLE;
    repeat (2) @(negedge clk);
    check_direct("reset_state", 1'b0);
    rst = 1'b1;

    // 1+5+1+10 = 17: ticket on the dime, 2c forfeited
    step("t1_penny",  PENNY,  1'b0);
    step("t1_nickel", NICKEL, 1'b0);
    step("t1_penny2", PENNY,  1'b0);
    step("t1_dime",   DIME,   1'b1);
    step("t1_fall",   IDLE,   1'b0);

    // Mid-cycle reset discards 10c; two dimes then complete
    step("t2_dime0", DIME, 1'b0);
    reset_pulse("t2_rst_clear");
    step("t2_dime1", DIME, 1'b0);
    step("t2_dime2", DIME, 1'b1);
    reset_pulse("t2_rst_ticket_drop");
    step("t2_idle", IDLE, 1'b0);

    // Coin during held reset is ignored: nickel+dime must be needed
    reset_over_edge("t2b_rst_hold", DIME);
    step("t2b_nickel", NICKEL, 1'b0);
    step("t2b_dime",   DIME,   1'b1);

    // Exact price with three nickels; following penny carries credit 1
    step("t3_n1", NICKEL, 1'b0);
    step("t3_n2", NICKEL, 1'b0);
    step("t3_n3", NICKEL, 1'b1);
    step("t3_penny", PENNY, 1'b0);
    step("t3_dime",  DIME,  1'b0);
    for (int i = 0; i < 3; i++) step("t3_penny_fill", PENNY, 1'b0);
    step("t3_penny_last", PENNY, 1'b1);

    // Fifteen pennies with an idle gap after seven
    for (int i = 0; i < 7; i++) step("t4_penny_a", PENNY, 1'b0);
    for (int i = 0; i < 5; i++) step("t4_idle", IDLE, 1'b0);
    for (int i = 0; i < 7; i++) step("t4_penny_b", PENNY, 1'b0);
    step("t4_penny_15", PENNY, 1'b1);
    step("t4_fall", IDLE, 1'b0);

    // 14c then reset; a completing penny during reset must not issue a ticket
    step("t5_dime", DIME, 1'b0);
    for (int i = 0; i < 4; i++) step("t5_penny", PENNY, 1'b0);
    reset_over_edge("t5_rst", PENNY);
    step("t5_nickel", NICKEL, 1'b0);
    step("t5_dime2",  DIME,   1'b1);

    // Dime/nickel back-to-back pairs
    step("t6_d1", DIME,   1'b0);
    step("t6_n1", NICKEL, 1'b1);
    step("t6_d2", DIME,   1'b0);
    step("t6_n2", NICKEL, 1'b1);
    step("t6_idle", IDLE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout ticket=%0b expected=finish", ticket);
    $fatal(1, "timeout");
  end

endmodule
